// File: rtl/seq_detect_sched.sv
// seq_detect_sched: one 2-bit Mealy falling-edge detector shared by N_CH serial
// bit-stream requesters. Each channel keeps its detector state as a saved context.
// A round-robin arbiter grants one eligible channel per cycle. The shared core
// computes that channel's next state and output. The result is registered.
//
// Handshake: channel k offers a bit by holding req_i[k]=1 with bit_i[k] stable.
// A transfer happens in the cycle where req_i[k] & gnt_o[k]. The result appears
// one clock later on det_valid_o/det_ch_o/det_y_o. There is no backpressure on results.
//
// Optional build macro: SEQ_SCHED_DETCNT_EN adds a saturating 16-bit detection
// counter (det_cnt_o) with a synchronous clear input (cnt_clr_i).
module seq_detect_sched #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req_i,
  input  logic [N_CH-1:0] bit_i,
  input  logic [N_CH-1:0] clr_i,
`ifdef SEQ_SCHED_DETCNT_EN
  input  logic            cnt_clr_i,
  output logic [15:0]     det_cnt_o,
`endif
  output logic [N_CH-1:0] gnt_o,
  output logic            det_valid_o,
  output logic [CH_W-1:0] det_ch_o,
  output logic            det_y_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t          r_ctx [N_CH];
  logic [CH_W-1:0] r_ptr;
  logic            r_det_valid;
  logic [CH_W-1:0] r_det_ch;
  logic            r_det_y;
  logic            r_busy;

  logic [N_CH-1:0] w_elig;
  logic            w_found;
  logic [CH_W-1:0] w_gidx;
  state_t          w_cur;
  state_t          w_next;
  logic            w_x;
  logic            w_y;

  // Channel index base+off, wrapped into 0..N_CH-1 (base < N_CH, off <= N_CH).
  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return s[CH_W-1:0];
  endfunction

  // Round-robin search from r_ptr over requesters that are not being cleared.
  always_comb begin
    w_elig  = req_i & ~clr_i;
    w_found = 1'b0;
    w_gidx  = '0;
    gnt_o   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && w_elig[wrap_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_gidx  = wrap_idx(r_ptr, i);
      end
    end
    if (w_found && rst_n) gnt_o[w_gidx] = 1'b1;
  end

  // Shared detector core: next state and Mealy output for the granted context.
  always_comb begin
    w_cur  = r_ctx[w_gidx];
    w_x    = bit_i[w_gidx];
    w_next = S0;
    case (w_cur)
      S0:      w_next = w_x ? S1 : S0;
      S1:      w_next = w_x ? S3 : S0;
      S3:      w_next = w_x ? S2 : S0;
      S2:      w_next = w_x ? S2 : S0;
      default: w_next = S0;
    endcase
    w_y = (w_cur != S0) && !w_x;
  end

  // Context store: a clear forces S0; otherwise only the granted context is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) r_ctx[k] <= S0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (clr_i[k]) r_ctx[k] <= S0;
        else if (w_found && (w_gidx == CH_W'(k))) r_ctx[k] <= w_next;
      end
    end
  end

  // Pointer advance and registered result; channel/y hold their values on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_det_valid <= 1'b0;
      r_det_ch    <= '0;
      r_det_y     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_det_valid <= w_found;
      r_busy      <= |req_i;
      if (w_found) begin
        r_ptr    <= wrap_idx(w_gidx, 1);
        r_det_ch <= w_gidx;
        r_det_y  <= w_y;
      end
    end
  end

  assign det_valid_o = r_det_valid;
  assign det_ch_o    = r_det_ch;
  assign det_y_o     = r_det_y;
  assign busy_o      = r_busy;

`ifdef SEQ_SCHED_DETCNT_EN
  logic [15:0] r_det_cnt;

  // Saturating count of y=1 transfers; the clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_det_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_det_cnt <= '0;
    end else if (w_found && w_y && (r_det_cnt != 16'hFFFF)) begin
      r_det_cnt <= r_det_cnt + 16'd1;
    end
  end

  assign det_cnt_o = r_det_cnt;
`endif

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Time-shares one 2-bit Mealy sequence-detector core among N_CH serial bit-stream requesters.
- Each channel's detector state is kept as a saved context. A round-robin arbiter picks one requester per cycle, loads that channel's context, applies its bit, writes the next state back and reports the Mealy output.
- Sits between per-channel serial front-ends and the event-collection logic, replacing N_CH separate detector instances.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- CH_W, 2, width of the channel index; N_CH <= 2**CH_W required.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_i  input  N_CH  per-channel request; bit k holds while channel k offers a bit.
- bit_i  input  N_CH  per-channel serial bit; stable while req_i[k]=1 and not yet granted.
- clr_i  input  N_CH  per-channel synchronous context clear to S0.
- gnt_o  output  N_CH  one-hot grant, combinational; transfer when req_i[k]&gnt_o[k].
- det_valid_o  output  1  registered; one result produced this cycle.
- det_ch_o  output  CH_W  registered; channel index of the result.
- det_y_o  output  1  registered; Mealy output for that transfer.
- busy_o  output  1  registered; any request was pending in the previous cycle.

Behaviour:
- Reset (async, rst_n=0):
  - All contexts go to S0 and the round-robin pointer goes to 0.
  - det_valid_o=0, det_ch_o=0, det_y_o=0, busy_o=0.
  - gnt_o=0 while rst_n=0.
- Detector core, states S0=00, S1=01, S2=10, S3=11:
  - Any state with x=0 -> S0.
  - S0 with x=1 -> S1; S1 with x=1 -> S3; S3 with x=1 -> S2; S2 with x=1 -> S2.
  - Output y = 1 when state != S0 and x = 0, else 0. This flags a 1->0 transition in a channel's stream.
  - An out-of-range context value behaves as S0.
- Arbitration:
  - Eligible channels: req_i[k]=1 and clr_i[k]=0.
  - Search starts at index ptr and proceeds ptr, ptr+1, ... with wrap at N_CH-1 -> 0.
  - The first eligible channel gets gnt_o. At most one grant per cycle; no grant if none is eligible.
  - On a grant to channel g, ptr <= (g+1) mod N_CH; otherwise ptr is unchanged.
- Transfer cycle for granted channel g:
  - ctx[g] <= next_state(ctx[g], bit_i[g]).
  - Next edge: det_valid_o=1, det_ch_o=g, det_y_o=y(ctx[g], bit_i[g]).
  - Latency: exactly 1 clock from grant to result.
- Idle cycle: det_valid_o=0. det_ch_o and det_y_o hold their last values.
- Throughput: one bit per cycle aggregate. A channel requesting continuously gets at least one grant every N_CH cycles.
- clr_i[k]=1:
  - ctx[k] <= S0 at the next edge and channel k is masked from the grant that cycle.
  - Clear overrides any update; other channels are unaffected.
- Contexts of non-granted channels are held unchanged.
- busy_o <= |req_i.
- Reset asserted mid-operation: any in-flight result is dropped and contexts return to S0.

Optional Feature:
- Macro SEQ_SCHED_DETCNT_EN.
- Defined:
  - Adds output det_cnt_o [15:0], registered, reset 0.
  - Increments by 1 at each edge where a transfer produces y=1.
  - Saturates at 16'hFFFF.
  - Input cnt_clr_i (1 bit) clears it synchronously; clear wins over increment.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 with req_i=4'b1111 -> gnt_o=0, all outputs 0. Release; first grant goes to ch0, then ch1, ch2, ch3, ch0 on consecutive cycles.
- Single channel ch2, bits 1,1,0 on three consecutive grants:
  - det_valid_o=1 and det_ch_o=2 on each following cycle.
  - det_y_o = 0, 0, 1.
  - ctx[2] goes S1, S3, S0.
- Context isolation: interleave ch0 stream 1,0 with ch1 stream 0,0 (req_i=4'b0011) -> ch0 reports y=0 then y=1; ch1 reports y=0 then y=0.
- Clear collision: ch1 in S3, req_i[1]=1 and clr_i[1]=1 in the same cycle -> gnt_o[1]=0 and ctx[1]=S0. The next bit 0 gives det_y_o=0.
- Fairness: req_i=4'b1111 held for 40 cycles -> each channel granted exactly 10 times, never twice within any 4-cycle window.
- SEQ_SCHED_DETCNT_EN defined: 5 falling-edge detections -> det_cnt_o=5. Pulse cnt_clr_i together with a detection -> det_cnt_o=0. Preload near saturation -> det_cnt_o holds 16'hFFFF.
